fetch_seq: RTL

- Instruction fetch and step sequencer; it is the producer side of the decoder block interface.
- Owns the program counter and the step counter.
- Fetches the opcode byte, then the 0-3 operand bytes the decoder requests via len, and presents insn/d1/d2/d3/is to the decoder.
- Consumes the decoder's pc_lrc/pc_ini/pc_cub strobes to advance steps, advance to the next instruction, or jump.

---
 rtl/fetch_seq_pkg.sv | 26 ++
 rtl/fetch_seq_pc_ctr.sv | 35 +++
 rtl/fetch_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : fetch_seq_pkg                                           |
// | Brief  : Shared types and constants for the fetch sequencer.     |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        DECODE   = 2'd1,
        FETCH_D  = 2'd2,
        EXEC     = 2'd3
    } state_t;

    localparam int          c_step_w   = 3;
    localparam logic [15:0] c_reset_pc = 16'h0000;

    // Bit positions of the decoder's pc control field, MSB first.
    localparam int c_pc_lrc_bit = 3;
    localparam int c_pc_ini_bit = 2;
    localparam int c_pc_cub_bit = 1;
    localparam int c_pc_oe_bit  = 0;

endpackage : fetch_seq_pkg
`default_nettype wire

// File: rtl/fetch_seq_pc_ctr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : pc_ctr                                                  |
// | Brief  : Program counter with load, increment and modulo wrap.   |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module pc_ctr #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] r_pc;

    // Load wins over increment; the add wraps naturally at 2^AW.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= load_val;
        end else if (inc) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    assign pc = r_pc;

endmodule : pc_ctr
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : fetch_seq                                               |
// | Brief  : Instruction fetch and step sequencer feeding decoder.   |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = AW'(c_reset_pc),
    parameter int            MAX_STEP = 7
) (
    input  logic                clk,
    input  logic                rst,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_re,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack,
    input  logic [1:0]          len,
    input  logic                pc_lrc,
    input  logic                pc_ini,
    input  logic                pc_cub,
    input  logic [AW-1:0]       jump_addr,
    output logic [7:0]          insn,
    output logic [7:0]          d1,
    output logic [7:0]          d2,
    output logic [7:0]          d3,
    output logic [c_step_w-1:0] is,
    output logic                exec,
    output logic [AW-1:0]       pc_q,
    output logic                fault
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mem_re;
    logic                w_mem_re_nxt;
    logic [1:0]          r_k;
    logic [1:0]          r_n;
    logic [7:0]          r_insn;
    logic [7:0]          r_d1;
    logic [7:0]          r_d2;
    logic [7:0]          r_d3;
    logic [c_step_w-1:0] r_is;
    logic [AW-1:0]       w_pc;
    logic                w_ack;
    logic                w_in_exec;
    logic                w_last_step;
    logic                w_leave;
    logic                w_overflow;
    logic                w_pc_load;
    logic                w_pc_inc;

    // An ack only counts against a request we actually issued.
    assign w_ack       = r_mem_re & mem_ack;
    assign w_in_exec   = (r_state == EXEC);
    assign w_last_step = (r_is == c_step_w'(MAX_STEP));
    assign w_leave     = pc_lrc | pc_ini | w_last_step;
    assign w_overflow  = w_in_exec & ~pc_lrc & ~pc_ini & w_last_step;
    assign w_pc_load   = w_in_exec & pc_lrc;
    assign w_pc_inc    = (w_ack & ((r_state == FETCH_OP) | (r_state == FETCH_D)))
                       | (w_in_exec & ~pc_lrc & ~pc_ini & pc_cub & ~w_last_step);

    pc_ctr #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_pc_load),
        .load_val (jump_addr),
        .inc      (w_pc_inc),
        .pc       (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= FETCH_OP;
            r_mem_re <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_re <= w_mem_re_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH_OP: if (w_ack) w_state_nxt = DECODE;
            DECODE:   w_state_nxt = (len == 2'd0) ? EXEC : FETCH_D;
            FETCH_D:  if (w_ack && ((r_n + 2'd1) == r_k)) w_state_nxt = EXEC;
            EXEC:     if (w_leave) w_state_nxt = FETCH_OP;
            default:  w_state_nxt = FETCH_OP;
        endcase
        // Request line follows the state we are about to enter.
        w_mem_re_nxt = (w_state_nxt == FETCH_OP) || (w_state_nxt == FETCH_D);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_insn <= 8'h00;
            r_d1   <= 8'h00;
            r_d2   <= 8'h00;
            r_d3   <= 8'h00;
            r_k    <= 2'd0;
            r_n    <= 2'd0;
            r_is   <= '0;
        end else begin
            case (r_state)
                FETCH_OP: begin
                    if (w_ack) begin
                        r_insn <= mem_rdata;
                        r_d1   <= 8'h00;
                        r_d2   <= 8'h00;
                        r_d3   <= 8'h00;
                    end
                end
                DECODE: begin
                    r_k <= len;
                    r_n <= 2'd0;
                end
                FETCH_D: begin
                    if (w_ack) begin
                        case (r_n)
                            2'd0:    r_d1 <= mem_rdata;
                            2'd1:    r_d2 <= mem_rdata;
                            default: r_d3 <= mem_rdata;
                        endcase
                        r_n <= r_n + 2'd1;
                    end
                end
                EXEC: begin
                    r_is <= w_leave ? '0 : r_is + c_step_w'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = w_pc;
    assign mem_re   = r_mem_re;
    assign insn     = r_insn;
    assign d1       = r_d1;
    assign d2       = r_d2;
    assign d3       = r_d3;
    assign is       = r_is;
    assign exec     = w_in_exec;
    assign pc_q     = w_pc;
    assign fault    = w_overflow;

endmodule : fetch_seq
`default_nettype wire
